stopwatch_timekeeper: RTL and testbench

//  Stopwatch core, downstream of the 50 MHz -> 100 Hz clock divider.
//  - Counts elapsed time in BCD, MM:SS.cc, advancing once per rising edge of CLK_100Hz.
//  - Runs entirely in the CLK_50_MHz domain; CLK_100Hz is sampled as data, never used as a clock.
//  - Start/stop and lap/reset pushbuttons drive a 4-state FSM; six BCD digits go to the 7-seg decoders.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_timekeeper_if.sv | 31 +++
 rtl/key_conditioner.sv | 51 +++++
 rtl/stopwatch_timekeeper.sv | 146 ++++++++++++++
 tb/tb_stopwatch_timekeeper.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Stopwatch shared types: FSM encoding, BCD digit limits,
// and the six-digit MM:SS.cc group (index 0 = cs_ones).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } sw_state_e;

  localparam int NUM_DIGITS = 6;
  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  function automatic logic [3:0] dig_limit(input int idx);
    return (idx == 3 || idx == 5) ? DIG_MAX5 : DIG_MAX9;
  endfunction

endpackage

// File: rtl/stopwatch_timekeeper_if.sv
// Display-side bundle of the stopwatch: six BCD digits
// plus run/lap status and the wrap pulse.
interface stopwatch_timekeeper_if;

  logic [3:0] cs_ones;
  logic [3:0] cs_tens;
  logic [3:0] s_ones;
  logic [3:0] s_tens;
  logic [3:0] m_ones;
  logic [3:0] m_tens;
  logic       running;
  logic       lap_active;
  logic       rollover;

  modport master (
    output cs_ones, cs_tens,
    output s_ones, s_tens,
    output m_ones, m_tens,
    output running, lap_active,
    output rollover
  );

  modport slave (
    input cs_ones, cs_tens,
    input s_ones, s_tens,
    input m_ones, m_tens,
    input running, lap_active,
    input rollover
  );

endinterface

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchroniser, tick-paced
// debounce, single-cycle pulse on accepted press.
module key_conditioner #(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic CLK_50_MHz,
  input  logic reset_n,
  input  logic key_n,
  input  logic tick,
  output logic press
);

  localparam int CW =
    (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed_q;
  logic [CW-1:0]          cnt_q;
  logic                   raw_pressed;
  logic                   differ;
  logic                   accept;

  assign raw_pressed = ~sync_q[SYNC_STAGES-1];
  assign differ      = raw_pressed ^ pressed_q;
  assign accept      = tick & differ &
                       (cnt_q == CW'(DEBOUNCE_TICKS - 1));
  assign press       = accept & raw_pressed;

  // Sync chain plus disagreement run counter, advanced on tick
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
      if (tick) begin
        if (!differ) begin
          cnt_q <= '0;
        end else if (accept) begin
          pressed_q <= raw_pressed;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch core: 100 Hz tick detect, control FSM,
// BCD MM:SS.cc counter chain and lap-freezable display.
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic CLK_50_MHz,
  input  logic reset_n,
  input  logic CLK_100Hz,
  input  logic start_stop_n,
  input  logic lap_reset_n,
  stopwatch_timekeeper_if.master sw_if
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic                   clk_edge_q;
  logic                   tick;
  logic                   start_p;
  logic                   lap_p;
  sw_state_e              state_q;
  sw_state_e              state_d;
  logic                   clear;
  logic                   counting;
  digits_t                live_q;
  digits_t                live_d;
  digits_t                disp_q;
  logic                   wrap;
  logic                   cy;
  logic                   rollover_q;

  assign tick = clk_sync_q[SYNC_STAGES-1] & ~clk_edge_q;

  // 100 Hz square wave sampled as data for edge detection
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '0;
      clk_edge_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], CLK_100Hz};
      clk_edge_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  key_conditioner #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_start (
    .CLK_50_MHz(CLK_50_MHz),
    .reset_n   (reset_n),
    .key_n     (start_stop_n),
    .tick      (tick),
    .press     (start_p)
  );

  key_conditioner #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_lap (
    .CLK_50_MHz(CLK_50_MHz),
    .reset_n   (reset_n),
    .key_n     (lap_reset_n),
    .tick      (tick),
    .press     (lap_p)
  );

  // Next state; start has priority over a same-cycle lap
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_p) state_d = RUNNING;
      end
      RUNNING: begin
        if (start_p)    state_d = PAUSED;
        else if (lap_p) state_d = LAP;
      end
      LAP: begin
        if (start_p)    state_d = PAUSED;
        else if (lap_p) state_d = RUNNING;
      end
      PAUSED: begin
        if (start_p) begin
          state_d = RUNNING;
        end else if (lap_p) begin
          state_d = IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign counting = tick &
                    ((state_q == RUNNING) || (state_q == LAP));

  // Ripple-carry BCD increment over the six digits
  always_comb begin
    live_d = live_q;
    cy     = counting;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cy) begin
        if (live_q[i] >= dig_limit(i)) begin
          live_d[i] = 4'd0;
        end else begin
          live_d[i] = live_q[i] + 4'd1;
          cy        = 1'b0;
        end
      end
    end
    wrap = cy;
    if (clear) begin
      live_d = '0;
      wrap   = 1'b0;
    end
  end

  // State, live count, wrap pulse and display registers
  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      live_q     <= '0;
      disp_q     <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      rollover_q <= wrap;
      if (state_q != LAP) disp_q <= live_q;
    end
  end

  assign sw_if.cs_ones    = disp_q[0];
  assign sw_if.cs_tens    = disp_q[1];
  assign sw_if.s_ones     = disp_q[2];
  assign sw_if.s_tens     = disp_q[3];
  assign sw_if.m_ones     = disp_q[4];
  assign sw_if.m_tens     = disp_q[5];
  assign sw_if.running    = (state_q == RUNNING) ||
                            (state_q == LAP);
  assign sw_if.lap_active = (state_q == LAP);
  assign sw_if.rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Directed bench for stopwatch_timekeeper with a
// centisecond-integer reference model checked each cycle.
module tb_stopwatch_timekeeper;

  localparam int S    = 2;
  localparam int D    = 2;
  localparam int MAXV = 359999;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mst_e;

  logic CLK_50_MHz   = 1'b0;
  logic reset_n      = 1'b1;
  logic CLK_100Hz    = 1'b0;
  logic start_stop_n = 1'b1;
  logic lap_reset_n  = 1'b1;

  stopwatch_timekeeper_if sw_if ();

  stopwatch_timekeeper #(
    .DEBOUNCE_TICKS(D),
    .SYNC_STAGES   (S)
  ) dut (
    .CLK_50_MHz  (CLK_50_MHz),
    .reset_n     (reset_n),
    .CLK_100Hz   (CLK_100Hz),
    .start_stop_n(start_stop_n),
    .lap_reset_n (lap_reset_n),
    .sw_if       (sw_if)
  );

  always #10 CLK_50_MHz = ~CLK_50_MHz;

  logic [23:0] dut_disp;
  assign dut_disp = {sw_if.m_tens, sw_if.m_ones,
                     sw_if.s_tens, sw_if.s_ones,
                     sw_if.cs_tens, sw_if.cs_ones};

  // reference model state
  mst_e m_state = M_IDLE;
  int   m_cnt   = 0;
  int   m_disp  = 0;
  logic m_roll  = 1'b0;
  logic mh_clk [0:S];
  logic mh_ss  [0:S];
  logic mh_lr  [0:S];
  int   low_run  [2];
  int   high_run [2];
  logic kp    [2];
  logic pulse [2];
  logic mt;
  logic smp;
  logic force_req = 1'b0;

  // checker bookkeeping
  int total = 0;
  int bad   = 0;
  int roll_seen = 0;
  int lit_req  = 0;
  int lit_seen = 0;
  int lit_kind = 0;
  string lit_name = "";
  logic [23:0] lit_d = '0;
  logic lit_r = 1'b0;
  logic lit_l = 1'b0;
  int lit_act = 0;
  int lit_exp = 0;

  function automatic logic [23:0] to_bcd(input int v);
    int cs;
    int sec;
    int mn;
    cs  = v % 100;
    sec = (v / 100) % 60;
    mn  = v / 6000;
    return {4'(mn / 10), 4'(mn % 10),
            4'(sec / 10), 4'(sec % 10),
            4'(cs / 10), 4'(cs % 10)};
  endfunction

  // model: elapsed centiseconds as a plain integer
  always @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      m_disp  = 0;
      m_roll  = 1'b0;
      for (int j = 0; j <= S; j++) begin
        mh_clk[j] = 1'b0;
        mh_ss[j]  = 1'b0;
        mh_lr[j]  = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        low_run[k]  = 0;
        high_run[k] = 0;
        kp[k]       = 1'b0;
        pulse[k]    = 1'b0;
      end
    end else begin
      mt = mh_clk[S-1] && !mh_clk[S];
      if (force_req) m_cnt = MAXV;
      for (int k = 0; k < 2; k++) begin
        pulse[k] = 1'b0;
        if (mt) begin
          smp = (k == 0) ? mh_ss[S-1] : mh_lr[S-1];
          if (!smp) begin
            low_run[k]++;
            high_run[k] = 0;
          end else begin
            high_run[k]++;
            low_run[k] = 0;
          end
          if (!kp[k] && low_run[k] >= D) begin
            kp[k]    = 1'b1;
            pulse[k] = 1'b1;
          end else if (kp[k] && high_run[k] >= D) begin
            kp[k] = 1'b0;
          end
        end
      end
      if (m_state != M_LAP) m_disp = m_cnt;
      m_roll = 1'b0;
      if (mt && (m_state == M_RUN || m_state == M_LAP)) begin
        if (m_cnt == MAXV) begin
          m_cnt  = 0;
          m_roll = 1'b1;
        end else begin
          m_cnt++;
        end
      end
      if (pulse[0]) begin
        if (m_state == M_IDLE || m_state == M_PAUSE)
          m_state = M_RUN;
        else
          m_state = M_PAUSE;
      end else if (pulse[1]) begin
        case (m_state)
          M_RUN:   m_state = M_LAP;
          M_LAP:   m_state = M_RUN;
          M_PAUSE: begin
            m_state = M_IDLE;
            m_cnt   = 0;
          end
          default: ;
        endcase
      end
      for (int j = S; j > 0; j--) begin
        mh_clk[j] = mh_clk[j-1];
        mh_ss[j]  = mh_ss[j-1];
        mh_lr[j]  = mh_lr[j-1];
      end
      mh_clk[0] = CLK_100Hz;
      mh_ss[0]  = start_stop_n;
      mh_lr[0]  = lap_reset_n;
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // single compare process: model every cycle + literals
  always @(negedge CLK_50_MHz) begin
    chk("display", int'(dut_disp), int'(to_bcd(m_disp)));
    chk("running", int'(sw_if.running),
        int'(m_state == M_RUN || m_state == M_LAP));
    chk("lap_active", int'(sw_if.lap_active),
        int'(m_state == M_LAP));
    chk("rollover", int'(sw_if.rollover), int'(m_roll));
    if (sw_if.rollover) roll_seen++;
    if (lit_seen != lit_req) begin
      if (lit_kind == 0) begin
        chk({lit_name, ".disp"}, int'(dut_disp), int'(lit_d));
        chk({lit_name, ".run"}, int'(sw_if.running),
            int'(lit_r));
        chk({lit_name, ".lap"}, int'(sw_if.lap_active),
            int'(lit_l));
      end else begin
        chk(lit_name, lit_act, lit_exp);
      end
      lit_seen = lit_req;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK_50_MHz);
    #1;
  endtask

  task automatic tick_once();
    CLK_100Hz = 1'b1;
    repeat (2) @(negedge CLK_50_MHz);
    #1 CLK_100Hz = 1'b0;
    repeat (2) @(negedge CLK_50_MHz);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_once();
  endtask

  task automatic lit_disp(input string nm, input logic [23:0] d,
                          input logic r, input logic l);
    lit_name = nm;
    lit_kind = 0;
    lit_d    = d;
    lit_r    = r;
    lit_l    = l;
    lit_req++;
    idle(1);
  endtask

  task automatic lit_int(input string nm, input int act,
                         input int exp);
    lit_name = nm;
    lit_kind = 1;
    lit_act  = act;
    lit_exp  = exp;
    lit_req++;
    idle(1);
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: run did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    #2 reset_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK_50_MHz);
      #1;
      CLK_100Hz    = ~CLK_100Hz;
      start_stop_n = ~start_stop_n;
      lap_reset_n  = ~lap_reset_n;
    end
    CLK_100Hz    = 1'b0;
    start_stop_n = 1'b1;
    lap_reset_n  = 1'b1;
    lit_disp("reset_hold", 24'h000000, 1'b0, 1'b0);
    reset_n = 1'b1;
    ticks(4);
    lit_disp("idle_after_reset", 24'h000000, 1'b0, 1'b0);

    start_stop_n = 1'b0;
    for (int i = 0; i < 6 && !sw_if.running; i++) tick_once();
    lit_disp("start_accept", 24'h000000, 1'b1, 1'b0);
    start_stop_n = 1'b1;
    ticks(150);
    lit_disp("run_150", 24'h000150, 1'b1, 1'b0);

    force dut.live_q = 24'h595999;
    force_req = 1'b1;
    @(posedge CLK_50_MHz);
    #1;
    release dut.live_q;
    force_req = 1'b0;
    idle(2);
    lit_disp("preload", 24'h595999, 1'b1, 1'b0);
    r0 = roll_seen;
    tick_once();
    idle(2);
    lit_disp("wrap", 24'h000000, 1'b1, 1'b0);
    lit_int("rollover_cycles", roll_seen - r0, 1);

    ticks(40);
    lit_disp("at_40", 24'h000040, 1'b1, 1'b0);
    lap_reset_n = 1'b0;
    for (int i = 0; i < 6 && !sw_if.lap_active; i++)
      tick_once();
    lit_disp("lap_enter", 24'h000041, 1'b1, 1'b1);
    lap_reset_n = 1'b1;
    ticks(60);
    lit_disp("lap_frozen", 24'h000041, 1'b1, 1'b1);
    lap_reset_n = 1'b0;
    for (int i = 0; i < 6 && sw_if.lap_active; i++)
      tick_once();
    lit_disp("lap_exit", 24'h000104, 1'b1, 1'b0);
    lap_reset_n = 1'b1;
    ticks(3);

    start_stop_n = 1'b0;
    ticks(2);
    start_stop_n = 1'b1;
    ticks(3);
    lit_disp("paused", 24'h000109, 1'b0, 1'b0);
    lap_reset_n = 1'b0;
    ticks(2);
    lap_reset_n = 1'b1;
    ticks(3);
    lit_disp("cleared", 24'h000000, 1'b0, 1'b0);
    lap_reset_n = 1'b0;
    ticks(2);
    lap_reset_n = 1'b1;
    ticks(3);
    lit_disp("lap_in_idle", 24'h000000, 1'b0, 1'b0);

    start_stop_n = 1'b0;
    tick_once();
    start_stop_n = 1'b1;
    ticks(3);
    lit_disp("glitch", 24'h000000, 1'b0, 1'b0);

    start_stop_n = 1'b0;
    lap_reset_n  = 1'b0;
    ticks(2);
    lit_disp("both_keys", 24'h000000, 1'b1, 1'b0);
    start_stop_n = 1'b1;
    lap_reset_n  = 1'b1;
    ticks(3);
    lit_disp("after_both", 24'h000003, 1'b1, 1'b0);

    reset_n = 1'b0;
    lit_disp("mid_reset", 24'h000000, 1'b0, 1'b0);
    idle(2);
    reset_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
